// File: rtl/gf180mcu_dlycal_pkg.sv
// Shared types for the gf180mcu delay-line calibration controller.
// This file holds the controller state encoding, the tap-step direction
// encoding, and helpers that the FSM uses.
package gf180mcu_dlycal_pkg;

    // State table for gf180mcu_dlycal_ctrl:
    //   state       | meaning
    //   ST_IDLE     | waiting for START; TAP_SEL held
    //   ST_MEASURE  | ring enabled, counting OSC_EDGE for WINDOW cycles
    //   ST_COMPARE  | one cycle: edge count vs TARGET, pick direction
    //   ST_ADJUST   | one cycle: step tap, or lock on reversal, or error at rail
    //   ST_LOCKED   | converged; LOCK high, TAP_SEL held
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_COMPARE = 3'd2,
        ST_ADJUST  = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    // UP lengthens the delay line (ring too fast), DOWN shortens it.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    // A reversal is only meaningful once a step has been taken.
    function automatic logic is_reversal(input dir_t prev_dir, input dir_t cur_dir);
        return (prev_dir != DIR_NONE) && (prev_dir != cur_dir);
    endfunction

    // True when stepping in the given direction would run off the tap range.
    function automatic logic at_rail(input dir_t dir, input logic tap_max, input logic tap_min);
        return ((dir == DIR_UP) && tap_max) || ((dir == DIR_DOWN) && tap_min);
    endfunction

endpackage

// File: rtl/gf180mcu_dlycal_win.sv
// Measurement window for the delay-line calibration controller.
// A down-counting window timer, plus a saturating counter of
// ring-oscillator edges.
// 'clear' reloads the timer and zeroes the count. While 'run' is high, each
// cycle counts one OSC edge (if present) and decrements the timer. 'done' is
// high in the last cycle of the window, so the count seen in the following
// cycle covers exactly WINDOW samples.
module gf180mcu_dlycal_win #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic             osc_edge,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] timer;

    // Window timer: reload on clear, count down to terminal zero while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= TMR_LOAD;
        end else if (clear) begin
            timer <= TMR_LOAD;
        end else if (run && (timer != '0)) begin
            timer <= timer - 1'b1;
        end
    end

    // Edge counter: saturates rather than wrapping so a very fast ring still
    // reads as "too fast".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && osc_edge && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign done = run && (timer == '0);

endmodule

// File: rtl/gf180mcu_dlycal_ctrl.sv
// Delay-line (inverter-chain) calibration controller for gf180mcu.
// This block measures the ring-oscillator edge count over a fixed window.
// It then steps the tap select toward TARGET until the count matches or
// the direction reverses. It flags an error if the tap range runs out.
// Optional build macro GF180MCU_DLYCAL_HYST_EN adds a TOL input: counts
// within +/-TOL of TARGET are then treated as a match.
module gf180mcu_dlycal_ctrl
    import gf180mcu_dlycal_pkg::*;
#(
    parameter int TAP_W    = 4,
    parameter int CNT_W    = 8,
    parameter int WINDOW   = 16,
    parameter int TAP_INIT = 2 ** (TAP_W - 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] TARGET,
`ifdef GF180MCU_DLYCAL_HYST_EN
    input  logic [CNT_W-1:0] TOL,
`endif
    input  logic             OSC_EDGE,
    output logic             OSC_EN,
    output logic [TAP_W-1:0] TAP_SEL,
    output logic             BUSY,
    output logic             LOCK,
    output logic             ERR
);

    localparam logic [TAP_W-1:0] TAP_RST = TAP_W'(TAP_INIT);
    localparam logic [TAP_W-1:0] TAP_MAX = {TAP_W{1'b1}};

    state_t           state;
    dir_t             cur_dir;
    dir_t             last_dir;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] edge_cnt;
    logic             win_done;
    logic             win_clear;
    logic             win_run;
    logic             start_acc;
    logic             in_tol;
    logic             ring_fast;
`ifdef GF180MCU_DLYCAL_HYST_EN
    logic [CNT_W-1:0] tol_q;
    logic [CNT_W-1:0] cnt_diff;
`endif

    assign start_acc = START && ((state == ST_IDLE) || (state == ST_LOCKED));
    assign win_clear = start_acc || (state == ST_ADJUST);
    assign win_run   = (state == ST_MEASURE);
    assign ring_fast = (edge_cnt > target_q);

    gf180mcu_dlycal_win #(
        .CNT_W  (CNT_W),
        .WINDOW (WINDOW)
    ) u_win (
        .clk      (CLK),
        .rst      (RST),
        .clear    (win_clear),
        .run      (win_run),
        .osc_edge (OSC_EDGE),
        .count    (edge_cnt),
        .done     (win_done)
    );

    // Match decision: exact equality, or within +/-TOL when hysteresis is built in.
    always_comb begin
        in_tol = 1'b0;
`ifdef GF180MCU_DLYCAL_HYST_EN
        cnt_diff = '0;
        if (ring_fast) begin
            cnt_diff = edge_cnt - target_q;
        end else begin
            cnt_diff = target_q - edge_cnt;
        end
        in_tol = (cnt_diff <= tol_q);
`else
        in_tol = (edge_cnt == target_q);
`endif
    end

    // Calibration FSM with registered outputs; each transition sets the
    // outputs that belong to the state being entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            TAP_SEL  <= TAP_RST;
            OSC_EN   <= 1'b0;
            BUSY     <= 1'b0;
            LOCK     <= 1'b0;
            ERR      <= 1'b0;
            target_q <= '0;
            cur_dir  <= DIR_NONE;
            last_dir <= DIR_NONE;
`ifdef GF180MCU_DLYCAL_HYST_EN
            tol_q    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_LOCKED: begin
                    if (START) begin
                        target_q <= TARGET;
`ifdef GF180MCU_DLYCAL_HYST_EN
                        tol_q    <= TOL;
`endif
                        LOCK     <= 1'b0;
                        ERR      <= 1'b0;
                        cur_dir  <= DIR_NONE;
                        last_dir <= DIR_NONE;
                        OSC_EN   <= 1'b1;
                        BUSY     <= 1'b1;
                        state    <= ST_MEASURE;
                    end
                end

                ST_MEASURE: begin
                    if (win_done) begin
                        OSC_EN <= 1'b0;
                        state  <= ST_COMPARE;
                    end
                end

                ST_COMPARE: begin
                    if (in_tol) begin
                        LOCK  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= ST_LOCKED;
                    end else begin
                        cur_dir <= ring_fast ? DIR_UP : DIR_DOWN;
                        state   <= ST_ADJUST;
                    end
                end

                ST_ADJUST: begin
                    if (is_reversal(last_dir, cur_dir)) begin
                        // Dithering across the target: the current tap is the best we get.
                        LOCK  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= ST_LOCKED;
                    end else if (at_rail(cur_dir, TAP_SEL == TAP_MAX, TAP_SEL == '0)) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        if (cur_dir == DIR_UP) begin
                            TAP_SEL <= TAP_SEL + 1'b1;
                        end else begin
                            TAP_SEL <= TAP_SEL - 1'b1;
                        end
                        last_dir <= cur_dir;
                        OSC_EN   <= 1'b1;
                        state    <= ST_MEASURE;
                    end
                end

                default: begin
                    OSC_EN <= 1'b0;
                    BUSY   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gf180mcu_dlycal_ctrl.md
GF180MCU_DLYCAL_CTRL -- requirements
Module: gf180mcu_dlycal_ctrl

Interface
REQ-001 SHALL have parameter TAP_W, default 4, width of inverter-chain tap select.
REQ-002 SHALL have parameter CNT_W, default 8, width of edge counter and TARGET.
REQ-003 SHALL have parameter WINDOW, default 16, measurement window length in CLK cycles (2..2^CNT_W-1).
REQ-004 SHALL have parameter TAP_INIT, default 2^(TAP_W-1), tap code loaded at reset.
REQ-005 SHALL have port CLK input 1, sole clock; all state on rising edge.
REQ-006 SHALL have port RST input 1, reset, asynchronous and active-high.
REQ-007 SHALL have port START input 1, single-cycle calibration request.
REQ-008 SHALL have port TARGET input CNT_W, desired edge count per window, sampled on accepted START.
REQ-009 SHALL have port OSC_EDGE input 1, ring-oscillator edge pulse, already synchronized to CLK.
REQ-010 SHALL have port OSC_EN output 1, enable for the inverter ring under calibration.
REQ-011 SHALL have port TAP_SEL output TAP_W, inverter-pair tap select driving the delay line.
REQ-012 SHALL have port BUSY output 1, high while not in IDLE or LOCKED.
REQ-013 SHALL have port LOCK output 1, calibration converged.
REQ-014 SHALL have port ERR output 1, tap range exhausted.

Function
REQ-015 SHALL implement states IDLE, MEASURE, COMPARE, ADJUST, LOCKED.
REQ-016 SHALL in IDLE or LOCKED accept START: latch TARGET, clear LOCK and ERR, clear edge count, enter MEASURE next cycle; START in other states SHALL be ignored.
REQ-017 SHALL in MEASURE drive OSC_EN=1 and stay exactly WINDOW cycles, counting OSC_EDGE pulses; count SHALL saturate at 2^CNT_W-1.
REQ-018 SHALL drive OSC_EN=0 in every state except MEASURE; OSC_EDGE outside MEASURE SHALL be ignored.
REQ-019 SHALL in COMPARE (one cycle): count==TARGET -> LOCKED; count>TARGET (ring too fast) -> direction UP; count<TARGET -> direction DOWN; then ADJUST.
REQ-020 SHALL in ADJUST (one cycle): increment TAP_SEL for UP, decrement for DOWN, clear edge count, return to MEASURE.
REQ-021 SHALL, if direction reverses relative to the previous ADJUST of the same calibration, skip the step and enter LOCKED with the current TAP_SEL (dither guard).
REQ-022 SHALL, if UP is required at TAP_SEL=2^TAP_W-1 or DOWN at TAP_SEL=0, leave TAP_SEL unchanged, set ERR=1, enter IDLE; no wrap-around.
REQ-023 SHALL set LOCK=1 on entry to LOCKED and hold it until next accepted START or RST.
REQ-024 SHALL hold TAP_SEL constant in IDLE and LOCKED.
REQ-025 SHALL have START-accepted to first COMPARE latency of 1+WINDOW cycles; each further iteration SHALL take WINDOW+2 cycles.

Reset
REQ-026 SHALL on RST asynchronously force state IDLE, TAP_SEL=TAP_INIT, OSC_EN=0, BUSY=0, LOCK=0, ERR=0, edge count 0, direction history cleared.
REQ-027 SHALL, if RST asserts mid-calibration, abandon it entirely; no state survives.

Configuration
REQ-028 SHALL, with macro GF180MCU_DLYCAL_HYST_EN defined, add input TOL (CNT_W) sampled with TARGET, and treat |count-TARGET|<=TOL as equal in COMPARE.
REQ-029 SHALL, without GF180MCU_DLYCAL_HYST_EN, have no TOL port and require exact equality.

Structure
REQ-030 SHALL place the state enum and direction encoding (UP, DOWN, NONE) in shared package gf180mcu_dlycal_pkg.
REQ-031 SHALL implement window timer plus saturating edge counter as sub-module gf180mcu_dlycal_win.

Verification (TAP_W=4, CNT_W=8, WINDOW=16, TAP_INIT=8)
REQ-032 SHALL cover: OSC_EDGE giving count 8 at TAP_SEL=8, TARGET=8, START -> LOCK=1 after 18 cycles, TAP_SEL=8, OSC_EN low.
REQ-033 SHALL cover: model count=16-TAP_SEL (one edge per tap step), TARGET=5 -> TAP_SEL steps 8,9,10,11, LOCK=1, ERR=0.
REQ-034 SHALL cover: count always 20, TARGET=5 -> TAP_SEL climbs to 15, then ERR=1, BUSY=0, TAP_SEL=15.
REQ-035 SHALL cover: count alternates 9/7 around TARGET=8 -> one step, then reversal -> LOCKED at single step away from 8.
REQ-036 SHALL cover: RST pulsed during MEASURE -> immediately OSC_EN=0, TAP_SEL=8, BUSY=0; START during MEASURE ignored.
REQ-037 SHALL cover, with GF180MCU_DLYCAL_HYST_EN: TARGET=8, TOL=1, count 9 -> LOCK=1 with no TAP_SEL change.
